// File: rtl/data_mem_dma.sv
// data_mem_dma: byte-block copy/fill engine sitting in front of the data memory.
// Fill mode is compiled in only when DMA_FILL_MODE_EN is defined; otherwise every transfer is a copy.
module data_mem_dma #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Mode,
  input  logic [AW-1:0] SrcAddr,
  input  logic [AW-1:0] DstAddr,
  input  logic [AW-1:0] Len,
  input  logic [DW-1:0] FillVal,
  output logic          Busy,
  output logic          Done,
  input  logic          CpuWriteEn,
  input  logic [AW-1:0] CpuAddr,
  input  logic [DW-1:0] CpuDataIn,
  output logic [DW-1:0] CpuDataOut,
  output logic          MemWriteEn,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemDataIn,
  input  logic [DW-1:0] MemDataOut
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] buf_q, buf_d;
  logic          mode_q;
  logic          start_fill;
  logic [DW-1:0] wr_data;

`ifdef DMA_FILL_MODE_EN
  logic          mode_d;
  logic [DW-1:0] fill_q, fill_d;

  assign start_fill = Mode;
  assign wr_data    = mode_q ? fill_q : buf_q;

  // Transfer configuration is captured only when a Start is accepted.
  always_comb begin
    mode_d = mode_q;
    fill_d = fill_q;
    if (state_q == S_IDLE && Start) begin
      mode_d = Mode;
      fill_d = FillVal;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      mode_q <= 1'b0;
      fill_q <= '0;
    end else begin
      mode_q <= mode_d;
      fill_q <= fill_d;
    end
  end
`else
  logic unused_fill_cfg;

  assign start_fill      = 1'b0;
  assign mode_q          = 1'b0;
  assign wr_data         = buf_q;
  assign unused_fill_cfg = ^{Mode, FillVal};
`endif

  // NOTE: every output of this block gets a default before the case so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    MemWriteEn = 1'b0;
    MemAddr    = dst_q;
    MemDataIn  = wr_data;
    CpuDataOut = '0;

    case (state_q)
      S_IDLE: begin
        MemWriteEn = CpuWriteEn;
        MemAddr    = CpuAddr;
        MemDataIn  = CpuDataIn;
        CpuDataOut = MemDataOut;
        if (Start) begin
          src_d = SrcAddr;
          dst_d = DstAddr;
          cnt_d = Len;
          if (Len == '0)      state_d = S_DONE;
          else if (start_fill) state_d = S_WRITE;
          else                state_d = S_READ;
        end
      end
      S_READ: begin
        MemAddr = src_q;
        buf_d   = MemDataOut;
        src_d   = src_q + AW'(1);
        state_d = S_WRITE;
      end
      S_WRITE: begin
        MemAddr    = dst_q;
        MemWriteEn = 1'b1;
        dst_d      = dst_q + AW'(1);
        cnt_d      = cnt_q - AW'(1);
        if (cnt_q == AW'(1)) state_d = S_DONE;
        else if (mode_q)     state_d = S_WRITE;
        else                 state_d = S_READ;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign Busy = (state_q != S_IDLE);
  assign Done = (state_q == S_DONE);

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_data_mem_dma.sv
// Scoreboard bench for data_mem_dma: a behavioural memory, a byte-level reference copy of it,
// and a monitor that checks Done timing, Busy length and CPU load data against queued expectations.
module tb_data_mem_dma;

`ifdef DMA_FILL_MODE_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  typedef struct {
    int done_cyc;
    int busy_cyc;
  } xfer_exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, mode, cpu_we, load_strobe;
  logic [7:0] src, dst, len, fill, cpu_addr, cpu_din;
  logic       busy, done, mem_we;
  logic [7:0] cpu_dout, mem_addr, mem_wdata, mem_rdata;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  logic [7:0] init_val[256];

  xfer_exp_t  xq[$];
  logic [7:0] lq[$];
  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;
  int busy_run = 0;

  data_mem_dma #(.AW(8), .DW(8)) dut (
    .Clk(clk), .Reset(rst_n), .Start(start), .Mode(mode),
    .SrcAddr(src), .DstAddr(dst), .Len(len), .FillVal(fill),
    .Busy(busy), .Done(done),
    .CpuWriteEn(cpu_we), .CpuAddr(cpu_addr), .CpuDataIn(cpu_din), .CpuDataOut(cpu_dout),
    .MemWriteEn(mem_we), .MemAddr(mem_addr), .MemDataIn(mem_wdata), .MemDataOut(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Data memory: combinational read, write at the rising edge.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_mem(input string name);
    int a;
    a = 0;
    for (int i = 255; i >= 0; i--) if (mem[i] !== ref_mem[i]) a = i;
    check($sformatf("%s mem[0x%02h]", name, a), 32'(mem[a]), 32'(ref_mem[a]));
  endtask

  // Reference transfer: the end result of a forward, byte-serial copy or a fill.
  task automatic model_xfer(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n,
                            input bit is_fill, input logic [7:0] v);
    for (int i = 0; i < int'(n); i++)
      ref_mem[8'(d + 8'(i))] = is_fill ? v : ref_mem[8'(s + 8'(i))];
  endtask

  // Monitor: samples just after the falling edge, away from the active edge.
  always begin
    @(negedge clk);
    #1;
    if (!rst_n) busy_run = 0;
    else begin
      if (busy) busy_run++;
      if (load_strobe) begin
        if (lq.size() == 0) check("load_unexpected", 32'(cpu_dout), 32'hFFFF_FFFF);
        else check("cpu_load", 32'(cpu_dout), 32'(lq.pop_front()));
      end
      if (done) begin
        if (xq.size() == 0) check("done_unexpected", 32'(cyc), 32'hFFFF_FFFF);
        else begin
          xfer_exp_t e;
          e = xq.pop_front();
          check("done_cycle", 32'(cyc), 32'(e.done_cyc));
          check("busy_cycles", 32'(busy_run), 32'(e.busy_cyc));
        end
        busy_run = 0;
      end
    end
  end

  task automatic quiet();
    start = 1'b0; cpu_we = 1'b0; load_strobe = 1'b0;
  endtask

  task automatic cpu_store(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_we = 1'b1; cpu_addr = a; cpu_din = d;
    ref_mem[a] = d;
    @(negedge clk);
    cpu_we = 1'b0;
  endtask

  task automatic cpu_load(input logic [7:0] a);
    @(negedge clk);
    cpu_we = 1'b0; cpu_addr = a; load_strobe = 1'b1;
    lq.push_back(ref_mem[a]);
    @(negedge clk);
    load_strobe = 1'b0;
  endtask

  // One transfer; with noise, the CPU port and Start/config inputs are scrambled while busy.
  task automatic run_xfer(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n,
                          input bit m, input logic [7:0] v, input bit noise, input string name);
    int b;
    bit is_fill;
    xfer_exp_t e;
    is_fill = m & FILL_EN;
    b = (n == 0) ? 1 : (is_fill ? int'(n) + 1 : 2 * int'(n) + 1);
    @(negedge clk);
    start = 1'b1; mode = m; src = s; dst = d; len = n; fill = v;
    cpu_we = 1'b0; load_strobe = 1'b0;
    e.done_cyc = cyc + b;
    e.busy_cyc = b;
    xq.push_back(e);
    model_xfer(s, d, n, is_fill, v);
    for (int i = 0; i < b; i++) begin
      @(negedge clk);
      quiet();
      if (noise) begin
        start = 1'($urandom); mode = 1'($urandom);
        src = 8'($urandom); dst = 8'($urandom); len = 8'($urandom); fill = 8'($urandom);
        cpu_we = 1'($urandom); cpu_addr = 8'($urandom); cpu_din = 8'($urandom);
        load_strobe = 1'($urandom);
        if (load_strobe) lq.push_back(8'h00);
      end
    end
    @(negedge clk);
    quiet();
    check_mem(name);
  endtask

  // Reset asserted mid-cycle while the first READ after the first WRITE is in progress.
  task automatic abort_xfer(input logic [7:0] s, input logic [7:0] d);
    @(negedge clk);
    start = 1'b1; mode = 1'b0; src = s; dst = d; len = 8'd8;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy_async", 32'(busy), 32'd0);
    check("abort_done_async", 32'(done), 32'd0);
    ref_mem[d] = ref_mem[s];
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_mem("abort");
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; mode = 1'b0; cpu_we = 1'b0; load_strobe = 1'b0;
    src = '0; dst = '0; len = '0; fill = '0; cpu_addr = '0; cpu_din = '0;
    for (int i = 0; i < 256; i++) begin
      init_val[i] = 8'($urandom);
      mem[i] <= init_val[i];
      ref_mem[i] = init_val[i];
    end
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    rst_n = 1'b1;

    cpu_store(8'h20, 8'hA5);
    cpu_load(8'h20);

    for (int i = 0; i < 4; i++) cpu_store(8'(8'h10 + 8'(i)), 8'(i + 1));
    run_xfer(8'h10, 8'h40, 8'd4, 1'b0, 8'h00, 1'b0, "basic_copy");
    for (int i = 0; i < 4; i++) cpu_load(8'(8'h40 + 8'(i)));

    cpu_store(8'hFE, 8'd7); cpu_store(8'hFF, 8'd8); cpu_store(8'h00, 8'd9);
    run_xfer(8'hFE, 8'hFF, 8'd3, 1'b0, 8'h00, 1'b0, "wrap_copy");
    cpu_load(8'h00);

    run_xfer(8'h90, 8'h80, 8'd5, 1'b1, 8'h3C, 1'b0, "fill");
    cpu_load(8'h82);

    run_xfer(8'h48, 8'h60, 8'd8, 1'b0, 8'h00, 1'b1, "lockout_copy");
    cpu_load(8'h41);

    abort_xfer(8'hA0, 8'hC0);
    run_xfer(8'h30, 8'h31, 8'd0, 1'b0, 8'h00, 1'b0, "len_zero");

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 3))
        0:       cpu_store(8'($urandom), 8'($urandom));
        1:       cpu_load(8'($urandom));
        default: run_xfer(8'($urandom), 8'($urandom), 8'($urandom_range(0, 20)),
                          1'($urandom), 8'($urandom), 1'($urandom), "random_xfer");
      endcase
    end

    repeat (3) @(negedge clk);
    check("pending_done", 32'(xq.size()), 32'd0);
    check("pending_load", 32'(lq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_dma.md
# data_mem_dma

Byte-block copy/fill engine that sits directly upstream of the data memory and is the only master on its write/address port. In IDLE it passes the CPU's load/store port straight through to the memory. On `Start` it takes the port and moves `Len` bytes from `SrcAddr` to `DstAddr` using the memory's combinational read and sequential write. This offloads the CPU's byte-copy loops.

## Interface
- `AW`, 8, address width; memory depth is 2^AW
- `DW`, 8, data width
- `Clk`  in  1  rising-edge clock
- `Reset`  in  1  asynchronous, active-low reset
- `Start`  in  1  request; sampled only in IDLE
- `Mode`  in  1  0 = copy, 1 = fill; forced to 0 without `DMA_FILL_MODE_EN`
- `SrcAddr`  in  AW  first source byte (copy)
- `DstAddr`  in  AW  first destination byte
- `Len`  in  AW  byte count; 0 = no-op
- `FillVal`  in  DW  constant written in fill mode
- `Busy`  out  1  high from the cycle after an accepted `Start` through DONE
- `Done`  out  1  one-cycle completion pulse
- `CpuWriteEn`  in  1  CPU store strobe
- `CpuAddr`  in  AW  CPU address
- `CpuDataIn`  in  DW  CPU store data
- `CpuDataOut`  out  DW  CPU load data
- `MemWriteEn`  out  1  to memory `WriteEn`
- `MemAddr`  out  AW  to memory `DataAddress`
- `MemDataIn`  out  DW  to memory `DataIn`
- `MemDataOut`  in  DW  from memory `DataOut` (combinational read)

## Operation
- States: IDLE, READ, WRITE, DONE.
- **IDLE**
  - Pass-through: `MemWriteEn=CpuWriteEn`, `MemAddr=CpuAddr`, `MemDataIn=CpuDataIn`, `CpuDataOut=MemDataOut`.
  - On `Start=1`, latch `SrcAddr`, `DstAddr`, `Len`, `Mode`, `FillVal` into the src/dst pointers, remaining-count and config registers.
  - `Len=0` → DONE. Copy → READ. Fill → WRITE.
- **READ**
  - `MemAddr=src`, `MemWriteEn=0`.
  - At the clock edge: `buf<=MemDataOut`, `src<=src+1`; go to WRITE.
- **WRITE**
  - `MemAddr=dst`, `MemWriteEn=1`, `MemDataIn = Mode ? FillVal : buf`.
  - At the edge: `dst<=dst+1`, `cnt<=cnt-1`.
  - If `cnt==1` → DONE; else copy → READ, fill → WRITE.
- **DONE**
  - `Done=1`, `Busy=1`, `MemWriteEn=0`; next state IDLE.
- While not IDLE, CPU port is ignored: `CpuWriteEn` is gated off and `CpuDataOut=0`. The CPU treats `Busy` as a stall.
- Pointers are AW bits and wrap modulo 2^AW (255+1 → 0). The count register is AW bits; `Len` max is 255.
- Copy is strictly forward and byte-serial. If `DstAddr` lies in (`SrcAddr`, `SrcAddr+Len`), already-written bytes are re-read; this replication is the defined behaviour.
- `Start` outside IDLE is ignored with no queuing. Latched parameters are stable for the whole transfer regardless of input changes.

## Timing
- Reset (`Reset=0`), asynchronous, takes effect immediately:
  - state=IDLE; `Busy=0`, `Done=0`
  - src, dst, cnt, buf = 0
  - Mem outputs return to pass-through
- A reset mid-transfer aborts it. Bytes already written remain; no `Done` pulse.
- `Start` at edge k puts the engine in the first active state in cycle k+1.
- Copy of N bytes: 2N busy cycles plus 1 DONE cycle. `Done` is high in cycle k+2N+1, and IDLE resumes in cycle k+2N+2.
- Fill of N bytes: N cycles plus 1 DONE cycle.
- `Len=0`: `Done` in cycle k+1; no memory write.
- Writes land at the clock edge ending each WRITE cycle. A READ that follows in the next cycle sees the new value.

## Configuration
- `DMA_FILL_MODE_EN` defined: fill mode is available.
- Undefined: `FillVal` is unused, `Mode` is internally tied to 0 and every transfer is a copy. The WRITE→WRITE path and the `FillVal` mux are not synthesized.

## Test plan
- **Reset/pass-through:** assert `Reset=0` mid-cycle → `Busy=0`, `Done=0` asynchronously. Then in IDLE, CPU store 0xA5 to address 0x20 and load it back → `CpuDataOut=0xA5`.
- **Basic copy:** preload 0x10..0x13 = 1,2,3,4; Start src=0x10, dst=0x40, len=4 → 0x40..0x43 = 1,2,3,4. `Done` 9 cycles after `Start`; `Busy` high for exactly 9 cycles.
- **Wrap-around:** copy src=0xFE, dst=0xFF, len=3 with [0xFE]=7, [0xFF]=8, [0x00]=9 → forward overlap gives [0xFF]=7, [0x00]=7, [0x01]=7; pointers wrap with no X.
- **Fill (with `DMA_FILL_MODE_EN`):** fill dst=0x80, len=5, val=0x3C → 0x80..0x84 = 0x3C, `Done` 6 cycles after `Start`. Without the macro, the same request performs a copy.
- **Busy lockout:** during a copy of len=8, pulse CPU store 0xFF to 0x41 and re-pulse `Start` → neither takes effect; `CpuDataOut=0`; exactly one `Done` pulse.
- **Abort and `Len=0`:** assert reset after 3 cycles of a len=8 copy → first byte written, rest untouched, no `Done`. Then Start len=0 → `Done` in the next cycle with no memory write.
